// File: rtl/riscv_arb_pkg.sv
// rtl/riscv_arb_pkg.sv - shared types and constants for the IF/DM memory arbiter
// Purpose: FSM state and owner encodings plus the fixed fetch access size.
// Ports: none (package).
package riscv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  // Instruction fetches are always full 64-bit reads.
  localparam logic [2:0] IF_SIZE = 3'b011;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// rtl/riscv_mem_arbiter_if.sv - bundle of fetch, data and downstream memory signals
// Purpose: groups every arbiter bus signal; clk/rstn stay outside.
// Modports: slave = arbiter view, master = environment (core + bus bridge) view.
interface riscv_mem_arbiter_if #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
);

  logic            if_req;
  logic [PLEN-1:0] if_adr;
  logic            if_ack;
  logic            if_err;
  logic [XLEN-1:0] if_q;
  logic            if_flush;

  logic            dm_req;
  logic [PLEN-1:0] dm_adr;
  logic [XLEN-1:0] dm_d;
  logic            dm_we;
  logic [2:0]      dm_size;
  logic            dm_ack;
  logic            dm_err;
  logic [XLEN-1:0] dm_q;

  logic            mem_req;
  logic [PLEN-1:0] mem_adr;
  logic [XLEN-1:0] mem_d;
  logic            mem_we;
  logic [2:0]      mem_size;
  logic            mem_ack;
  logic            mem_err;
  logic [XLEN-1:0] mem_q;

  modport slave (
    input  if_req, if_adr, if_flush,
    input  dm_req, dm_adr, dm_d, dm_we, dm_size,
    input  mem_ack, mem_err, mem_q,
    output if_ack, if_err, if_q,
    output dm_ack, dm_err, dm_q,
    output mem_req, mem_adr, mem_d, mem_we, mem_size
  );

  modport master (
    output if_req, if_adr, if_flush,
    output dm_req, dm_adr, dm_d, dm_we, dm_size,
    output mem_ack, mem_err, mem_q,
    input  if_ack, if_err, if_q,
    input  dm_ack, dm_err, dm_q,
    input  mem_req, mem_adr, mem_d, mem_we, mem_size
  );

endinterface

// File: rtl/riscv_arb_timeout.sv
// rtl/riscv_arb_timeout.sv - loadable cycle counter with expire flag
// Purpose: counts enabled cycles since the last load; expire marks the TIMEOUT-th one.
// Ports: clk, rstn (async active-low), load (clear count), en (count this cycle),
//        expire (this enabled cycle is number TIMEOUT; never set when TIMEOUT=0).
module riscv_arb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the number of enabled cycles already elapsed, so the match
  // fires during the TIMEOUT-th enabled cycle.
  assign expire = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - shares one memory port between fetch (IF) and data (DM)
// Purpose: fixed DM priority with IF starvation guard, one outstanding transfer,
//          fetch-flush discard and bus timeout.
// Ports: clk, rstn (async active-low), bus (riscv_mem_arbiter_if.slave).
module riscv_mem_arbiter
  import riscv_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  riscv_mem_arbiter_if.slave   bus
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t    state;
  arb_owner_t    owner;
  logic [SW-1:0] starve_cnt;
  logic          discard;
  logic          tmo_expire;
  logic          drop_if;

  riscv_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .load   (state == IDLE),
    .en     (state == BUSY),
    .expire (tmo_expire)
  );

  // A flush seen in the completing cycle itself still discards the response.
  assign drop_if = (owner == OWN_IF) && (discard || bus.if_flush);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      owner        <= OWN_IF;
      starve_cnt   <= '0;
      discard      <= 1'b0;
      bus.mem_req  <= 1'b0;
      bus.mem_adr  <= '0;
      bus.mem_d    <= '0;
      bus.mem_we   <= 1'b0;
      bus.mem_size <= '0;
      bus.if_ack   <= 1'b0;
      bus.if_err   <= 1'b0;
      bus.if_q     <= '0;
      bus.dm_ack   <= 1'b0;
      bus.dm_err   <= 1'b0;
      bus.dm_q     <= '0;
    end else begin
      bus.if_ack <= 1'b0;
      bus.if_err <= 1'b0;
      bus.dm_ack <= 1'b0;
      bus.dm_err <= 1'b0;
      case (state)
        IDLE: begin
          discard <= 1'b0;
          // DM wins unless IF is waiting and the guard has saturated.
          if (bus.dm_req && !(bus.if_req && starve_cnt == STARVE_MAX)) begin
            owner        <= OWN_DM;
            bus.mem_adr  <= bus.dm_adr;
            bus.mem_d    <= bus.dm_d;
            bus.mem_we   <= bus.dm_we;
            bus.mem_size <= bus.dm_size;
            bus.mem_req  <= 1'b1;
            state        <= BUSY;
            starve_cnt   <= bus.if_req ? starve_cnt + 1'b1 : '0;
          end else if (bus.if_req) begin
            owner        <= OWN_IF;
            bus.mem_adr  <= bus.if_adr;
            bus.mem_d    <= '0;
            bus.mem_we   <= 1'b0;
            bus.mem_size <= IF_SIZE;
            bus.mem_req  <= 1'b1;
            state        <= BUSY;
            starve_cnt   <= '0;
          end else begin
            starve_cnt   <= '0;
          end
        end
        BUSY: begin
          if (owner == OWN_IF && bus.if_flush) discard <= 1'b1;
          if (bus.mem_err || tmo_expire) begin
            bus.mem_req <= 1'b0;
            state       <= RESP;
            if (owner == OWN_DM) bus.dm_err <= 1'b1;
            else if (!drop_if)   bus.if_err <= 1'b1;
          end else if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            state       <= RESP;
            if (owner == OWN_DM) begin
              bus.dm_ack <= 1'b1;
              bus.dm_q   <= bus.mem_q;
            end else if (!drop_if) begin
              bus.if_ack <= 1'b1;
              bus.if_q   <= bus.mem_q;
            end
          end
        end
        RESP: begin
          // The ack/err pulse is on the outputs this cycle; no arbitration here.
          discard <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - directed self-checking bench for riscv_mem_arbiter
module tb_riscv_mem_arbiter;
  import riscv_arb_pkg::*;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  logic [63:0] exp_if_q;
  logic [63:0] exp_dm_q;

  riscv_mem_arbiter_if #(.XLEN(64), .PLEN(64)) bus ();

  riscv_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.if_adr   = '0;
    bus.if_flush = 1'b0;
    bus.dm_req   = 1'b0;
    bus.dm_adr   = '0;
    bus.dm_d     = '0;
    bus.dm_we    = 1'b0;
    bus.dm_size  = '0;
    bus.mem_ack  = 1'b0;
    bus.mem_err  = 1'b0;
    bus.mem_q    = '0;
  endtask

  // Waits (bounded) for mem_req, records the request, answers it for one cycle.
  task automatic serve(input logic [63:0] q, input logic err,
                       output logic [63:0] adr, output logic [2:0] size,
                       output logic we, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    adr  = bus.mem_adr;
    size = bus.mem_size;
    we   = bus.mem_we;
    if (seen) begin
      bus.mem_ack = 1'b1;
      bus.mem_err = err;
      bus.mem_q   = q;
      step();
      bus.mem_ack = 1'b0;
      bus.mem_err = 1'b0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    #3;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_size, bus.if_ack, bus.if_err, bus.dm_ack, bus.dm_err} !== 9'd0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {bus.mem_req, bus.mem_we, bus.mem_size, bus.if_ack, bus.if_err, bus.dm_ack, bus.dm_err});
    end
    checks++;
    if ({bus.mem_adr, bus.mem_d, bus.if_q, bus.dm_q} !== 256'd0) begin
      failures++;
      $display("FAIL reset_data: adr=%h d=%h if_q=%h dm_q=%h expected 0",
               bus.mem_adr, bus.mem_d, bus.if_q, bus.dm_q);
    end
    step();
    step();
    rstn = 1'b1;
    exp_if_q = '0;
    exp_dm_q = '0;
    step();
  endtask

  task automatic test_priority();
    bus.dm_req  = 1'b1;
    bus.dm_adr  = 64'h0000_1000;
    bus.dm_d    = 64'h1122_3344_5566_7788;
    bus.dm_we   = 1'b1;
    bus.dm_size = 3'b010;
    bus.if_req  = 1'b1;
    bus.if_adr  = 64'h0000_8000;
    step();  // cycle 1
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_adr !== 64'h0000_1000 || bus.mem_we !== 1'b1 ||
        bus.mem_size !== 3'b010 || bus.mem_d !== 64'h1122_3344_5566_7788) begin
      failures++;
      $display("FAIL prio_dm_grant: req=%b adr=%h we=%b size=%b d=%h expected 1 1000 1 010 1122334455667788",
               bus.mem_req, bus.mem_adr, bus.mem_we, bus.mem_size, bus.mem_d);
    end
    step();  // cycle 2
    bus.mem_ack = 1'b1;
    bus.mem_q   = 64'h0;
    step();  // cycle 3
    bus.mem_ack = 1'b0;
    checks++;
    if (bus.dm_ack !== 1'b1 || bus.mem_req !== 1'b0 || bus.if_ack !== 1'b0) begin
      failures++;
      $display("FAIL prio_dm_ack: dm_ack=%b mem_req=%b if_ack=%b expected 1 0 0",
               bus.dm_ack, bus.mem_req, bus.if_ack);
    end
    exp_dm_q = 64'h0;
    bus.dm_req = 1'b0;
    step();  // cycle 4: IDLE, IF wins
    checks++;
    if (bus.dm_ack !== 1'b0 || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL prio_idle: dm_ack=%b mem_req=%b expected 0 0", bus.dm_ack, bus.mem_req);
    end
    step();  // cycle 5
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_adr !== 64'h0000_8000 || bus.mem_size !== IF_SIZE ||
        bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL prio_if_grant: req=%b adr=%h size=%b we=%b expected 1 8000 011 0",
               bus.mem_req, bus.mem_adr, bus.mem_size, bus.mem_we);
    end
    bus.mem_ack = 1'b1;
    bus.mem_q   = 64'hCAFE_0001;
    step();  // cycle 6
    bus.mem_ack = 1'b0;
    checks++;
    if (bus.if_ack !== 1'b1 || bus.if_q !== 64'hCAFE_0001) begin
      failures++;
      $display("FAIL prio_if_ack: if_ack=%b if_q=%h expected 1 cafe0001", bus.if_ack, bus.if_q);
    end
    exp_if_q = 64'hCAFE_0001;
    bus.if_req = 1'b0;
    step();  // cycle 7: IDLE
    checks++;
    if (bus.if_ack !== 1'b0 || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL prio_if_pulse: if_ack=%b mem_req=%b expected 0 0", bus.if_ack, bus.mem_req);
    end
  endtask

  task automatic test_starvation();
    logic [63:0] adr;
    logic [2:0]  size;
    logic        we;
    bit          seen;
    bus.dm_req  = 1'b1;
    bus.dm_adr  = 64'h0000_2000;
    bus.dm_we   = 1'b0;
    bus.dm_size = 3'b011;
    bus.if_req  = 1'b1;
    bus.if_adr  = 64'h0000_9000;
    for (int g = 0; g < 5; g++) begin
      serve(64'h100 + 64'(g), 1'b0, adr, size, we, seen);
      checks++;
      if (!seen) begin
        failures++;
        $display("FAIL starve_timeout: grant %0d never requested", g);
      end else if (g < 4) begin
        exp_dm_q = 64'h100 + 64'(g);
        if (adr !== 64'h0000_2000 || bus.dm_ack !== 1'b1) begin
          failures++;
          $display("FAIL starve_dm_grant: grant %0d adr=%h dm_ack=%b expected 2000 1", g, adr, bus.dm_ack);
        end
      end else begin
        exp_if_q = 64'h104;
        if (adr !== 64'h0000_9000 || size !== 3'b011 || we !== 1'b0 || bus.if_ack !== 1'b1 ||
            bus.if_q !== 64'h104) begin
          failures++;
          $display("FAIL starve_if_grant: adr=%h size=%b we=%b if_ack=%b if_q=%h expected 9000 011 0 1 104",
                   adr, size, we, bus.if_ack, bus.if_q);
        end
      end
    end
    bus.dm_req = 1'b0;
    bus.if_req = 1'b0;
    step();
  endtask

  task automatic test_flush();
    logic [63:0] adr;
    logic [2:0]  size;
    logic        we;
    bit          seen;
    bus.if_req = 1'b1;
    bus.if_adr = 64'h0000_A000;
    step();  // BUSY
    bus.if_flush = 1'b1;
    step();
    bus.if_flush = 1'b0;
    bus.mem_ack  = 1'b1;
    bus.mem_q    = 64'hDEAD;
    step();  // RESP
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    checks++;
    if (bus.if_ack !== 1'b0 || bus.if_err !== 1'b0 || bus.if_q !== exp_if_q || bus.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_discard: if_ack=%b if_err=%b if_q=%h mem_req=%b expected 0 0 %h 0",
               bus.if_ack, bus.if_err, bus.if_q, bus.mem_req, exp_if_q);
    end
    step();  // IDLE
    bus.if_req = 1'b1;
    bus.if_adr = 64'h0000_A008;
    serve(64'hBEEF, 1'b0, adr, size, we, seen);
    checks++;
    if (!seen || bus.if_ack !== 1'b1 || bus.if_q !== 64'hBEEF || adr !== 64'h0000_A008) begin
      failures++;
      $display("FAIL flush_next: seen=%b if_ack=%b if_q=%h adr=%h expected 1 1 beef a008",
               seen, bus.if_ack, bus.if_q, adr);
    end
    exp_if_q = 64'hBEEF;
    bus.if_req = 1'b0;
    step();
  endtask

  task automatic test_err_wins();
    logic [63:0] adr;
    logic [2:0]  size;
    logic        we;
    bit          seen;
    bus.dm_req  = 1'b1;
    bus.dm_adr  = 64'h0000_3000;
    bus.dm_d    = 64'h55;
    bus.dm_we   = 1'b1;
    bus.dm_size = 3'b000;
    serve(64'h7777, 1'b1, adr, size, we, seen);
    checks++;
    if (!seen || we !== 1'b1 || bus.dm_err !== 1'b1 || bus.dm_ack !== 1'b0 || bus.dm_q !== exp_dm_q) begin
      failures++;
      $display("FAIL err_wins: seen=%b we=%b dm_err=%b dm_ack=%b dm_q=%h expected 1 1 1 0 %h",
               seen, we, bus.dm_err, bus.dm_ack, bus.dm_q, exp_dm_q);
    end
    bus.dm_req = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int n;
    bus.dm_req  = 1'b1;
    bus.dm_adr  = 64'h0000_4000;
    bus.dm_we   = 1'b0;
    bus.dm_size = 3'b011;
    step();
    n = 0;
    while (bus.mem_req === 1'b1 && n < 30) begin
      n++;
      step();
    end
    checks++;
    if (n != 8 || bus.dm_err !== 1'b1 || bus.dm_ack !== 1'b0) begin
      failures++;
      $display("FAIL timeout_abort: busy_cycles=%0d dm_err=%b dm_ack=%b expected 8 1 0", n, bus.dm_err, bus.dm_ack);
    end
    bus.dm_req = 1'b0;
    step();
    step();
    checks++;
    if (bus.dm_err !== 1'b0 || bus.mem_req !== 1'b0 || bus.dm_q !== exp_dm_q) begin
      failures++;
      $display("FAIL timeout_idle: dm_err=%b mem_req=%b dm_q=%h expected 0 0 %h",
               bus.dm_err, bus.mem_req, bus.dm_q, exp_dm_q);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.if_req = 1'b1;
    bus.if_adr = 64'h0000_B000;
    step();
    checks++;
    if (bus.mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_busy: mem_req=%b expected 1", bus.mem_req);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_adr, bus.mem_size, bus.if_q, bus.dm_q} !== 196'd0) begin
      failures++;
      $display("FAIL rst_mid_async: mem_req=%b adr=%h size=%b if_q=%h dm_q=%h expected 0",
               bus.mem_req, bus.mem_adr, bus.mem_size, bus.if_q, bus.dm_q);
    end
    bus.if_req = 1'b0;
    step();
    rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if ({bus.if_ack, bus.if_err, bus.dm_ack, bus.dm_err, bus.mem_req} !== 5'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_mid_quiet: %0d cycles with ack/err/mem_req set, expected 0", bad);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_priority();
    test_starvation();
    test_flush();
    test_err_wins();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
